// File: rtl/bcd_display_pkg.sv
// Shared widths and active-high seven-segment patterns (bit0=a .. bit6=g).
package bcd_display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD to active-high seven-segment decoder; non-decimal codes show a dash.
module bcd_seg_decoder
  import bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] iBcd,
  output logic [SEG_W-1:0] oSeg_c
);

  always_comb begin
    oSeg_c = SEG_DASH;
    case (iBcd)
      4'd0:    oSeg_c = SEG_0;
      4'd1:    oSeg_c = SEG_1;
      4'd2:    oSeg_c = SEG_2;
      4'd3:    oSeg_c = SEG_3;
      4'd4:    oSeg_c = SEG_4;
      4'd5:    oSeg_c = SEG_5;
      4'd6:    oSeg_c = SEG_6;
      4'd7:    oSeg_c = SEG_7;
      4'd8:    oSeg_c = SEG_8;
      4'd9:    oSeg_c = SEG_9;
      default: oSeg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed BCD display scanner with frame-synchronous updates,
// leading-zero blanking and output-stage polarity control.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b0,
  parameter bit          ACTIVE_LOW_DIG = 1'b0,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic                        iLoad,
  input  logic [BCD_W*NUM_DIGITS-1:0] iBcd,
  input  logic [NUM_DIGITS-1:0]       iDp,
  input  logic                        iEnable,
  output logic [SEG_W-1:0]            oSeg,
  output logic                        oDp,
  output logic [NUM_DIGITS-1:0]       oDigit,
  output logic                        oFrame
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;

  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ACTIVE_LOW_DIG}};

  logic [PRE_W-1:0]      preCnt;
  logic [IDX_W-1:0]      digIdx;
  logic [DATA_W-1:0]     pendBcd;
  logic [NUM_DIGITS-1:0] pendDp;
  logic                  pendFlag;
  logic [DATA_W-1:0]     dispBcd;
  logic [NUM_DIGITS-1:0] dispDp;

  logic                  preTc_c;
  logic                  wrap_c;
  logic [BCD_W-1:0]      curBcd_c;
  logic                  curDp_c;
  logic                  curBlank_c;
  logic                  upperZero_c;
  logic [SEG_W-1:0]      decSeg_c;
  logic [NUM_DIGITS-1:0] digOneHot_c;

  assign preTc_c     = (preCnt == PRE_W'(SCAN_DIV - 1));
  assign wrap_c      = preTc_c && (digIdx == IDX_W'(NUM_DIGITS - 1));
  assign digOneHot_c = NUM_DIGITS'(1) << digIdx;

  // Prescaler and digit index
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      preCnt <= '0;
      digIdx <= '0;
    end else if (preTc_c) begin
      preCnt <= '0;
      digIdx <= wrap_c ? '0 : digIdx + IDX_W'(1);
    end else begin
      preCnt <= preCnt + PRE_W'(1);
    end
  end

  // Pending/display double buffer; a load on the wrap cycle lands in pending after the transfer
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pendBcd  <= '0;
      pendDp   <= '0;
      pendFlag <= 1'b0;
      dispBcd  <= '0;
      dispDp   <= '0;
    end else begin
      if (wrap_c && pendFlag) begin
        dispBcd  <= pendBcd;
        dispDp   <= pendDp;
        pendFlag <= 1'b0;
      end
      if (iLoad) begin
        pendBcd  <= iBcd;
        pendDp   <= iDp;
        pendFlag <= 1'b1;
      end
    end
  end

  // Digit mux; walking down from the top tracks whether everything above is zero
  always_comb begin
    curBcd_c    = '0;
    curDp_c     = 1'b0;
    curBlank_c  = 1'b0;
    upperZero_c = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upperZero_c = upperZero_c && (dispBcd[i*BCD_W +: BCD_W] == '0);
      if (digIdx == IDX_W'(i)) begin
        curBcd_c   = dispBcd[i*BCD_W +: BCD_W];
        curDp_c    = dispDp[i];
        curBlank_c = BLANK_LEADING && (i != 0) && upperZero_c;
      end
    end
  end

  bcd_seg_decoder uDecoder (
    .iBcd   (curBcd_c),
    .oSeg_c (decSeg_c)
  );

  // Output registers; polarity applied only here
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSeg   <= SEG_OFF;
      oDp    <= ACTIVE_LOW_SEG;
      oDigit <= DIG_OFF;
      oFrame <= 1'b0;
    end else begin
      oFrame <= wrap_c;
      if (iEnable) begin
        oSeg   <= (curBlank_c ? SEG_BLANK : decSeg_c) ^ SEG_OFF;
        oDp    <= curDp_c ^ ACTIVE_LOW_SEG;
        oDigit <= digOneHot_c ^ DIG_OFF;
      end else begin
        oSeg   <= SEG_OFF;
        oDp    <= ACTIVE_LOW_SEG;
        oDigit <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: three polarity/blanking variants
// checked every cycle against a frame-level behavioural model.
module tb_bcd_display_scan;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRM = N * DIV;

  logic        clk = 1'b0;
  logic        rstN;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        en;

  logic [6:0] segA, segB, segC;
  logic       dpA, dpB, dpC;
  logic [3:0] digA, digB, digC;
  logic       frA, frB, frC;

  always #5 clk = ~clk;

  bcd_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW_SEG(1'b0),
                     .ACTIVE_LOW_DIG(1'b0), .BLANK_LEADING(1'b1)) dutA (
    .iClk(clk), .iRst_n(rstN), .iLoad(load), .iBcd(bcd), .iDp(dp), .iEnable(en),
    .oSeg(segA), .oDp(dpA), .oDigit(digA), .oFrame(frA));

  bcd_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW_SEG(1'b1),
                     .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b1)) dutB (
    .iClk(clk), .iRst_n(rstN), .iLoad(load), .iBcd(bcd), .iDp(dp), .iEnable(en),
    .oSeg(segB), .oDp(dpB), .oDigit(digB), .oFrame(frB));

  bcd_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW_SEG(1'b1),
                     .ACTIVE_LOW_DIG(1'b0), .BLANK_LEADING(1'b0)) dutC (
    .iClk(clk), .iRst_n(rstN), .iLoad(load), .iBcd(bcd), .iDp(dp), .iEnable(en),
    .oSeg(segC), .oDp(dpC), .oDigit(digC), .oFrame(frC));

  // Segment table written straight from the a..g letter lists
  logic [6:0] segTab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                              7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] c;
  } exp_t;

  exp_t sbQ[$];

  int nCheck = 0;
  int nPass  = 0;

  int         mCyc;
  int         mDisp;
  logic [3:0] mDispDp;
  int         mPend;
  logic [3:0] mPendDp;
  bit         mFlag;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    nCheck++;
    if (act === exp) nPass++;
    else $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
  endtask

  function automatic logic [12:0] inactive(input bit lowSeg, input bit lowDig);
    return {{7{lowSeg}}, lowSeg, {4{lowDig}}, 1'b0};
  endfunction

  function automatic logic [12:0] expOut(input bit lowSeg, input bit lowDig, input bit blk,
                                         input bit enable, input int idx, input bit fr);
    logic [6:0] s;
    logic       d;
    logic [3:0] g;
    int         upper;
    if (!enable) begin
      s = '0; d = 1'b0; g = '0;
    end else begin
      upper = mDisp >> (4 * idx);
      s = segTab[upper & 15];
      if (blk && idx > 0 && upper == 0) s = '0;
      d = mDispDp[idx];
      g = 4'(1 << idx);
    end
    return {s ^ {7{lowSeg}}, d ^ lowSeg, g ^ {4{lowDig}}, fr};
  endfunction

  // Reference model: digit position and frame boundary follow from the cycle count
  always @(posedge clk) begin : modelBlk
    exp_t e;
    int   idx;
    bit   wrapNow;
    if (!rstN) begin
      mCyc = 0; mDisp = 0; mDispDp = '0; mPend = 0; mPendDp = '0; mFlag = 1'b0;
      e.a = inactive(1'b0, 1'b0);
      e.b = inactive(1'b1, 1'b1);
      e.c = inactive(1'b1, 1'b0);
      sbQ.push_back(e);
    end else begin
      idx     = (mCyc / DIV) % N;
      wrapNow = (mCyc % FRM) == FRM - 1;
      e.a = expOut(1'b0, 1'b0, 1'b1, en, idx, wrapNow);
      e.b = expOut(1'b1, 1'b1, 1'b1, en, idx, wrapNow);
      e.c = expOut(1'b1, 1'b0, 1'b0, en, idx, wrapNow);
      sbQ.push_back(e);
      if (wrapNow && mFlag) begin
        mDisp = mPend; mDispDp = mPendDp; mFlag = 1'b0;
      end
      if (load) begin
        mPend = int'(bcd); mPendDp = dp; mFlag = 1'b1;
      end
      mCyc++;
    end
  end

  // Monitor: outputs are presented every cycle, sampled mid-period
  always @(negedge clk) begin : monBlk
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check("outA", {segA, dpA, digA, frA}, e.a);
      check("outB", {segB, dpB, digB, frB}, e.b);
      check("outC", {segC, dpC, digC, frC}, e.c);
    end
  end

  task automatic loadVal(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load = 1'b1; bcd = v; dp = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge just before the edge whose pre-edge cycle index is m (mod frame)
  task automatic waitPhase(input int m);
    int guard = 0;
    @(negedge clk);
    while ((mCyc % FRM) != m && guard < 2 * FRM) begin
      @(negedge clk);
      guard++;
    end
    if ((mCyc % FRM) != m) check("phaseTimeout", 13'd1, 13'd0);
  endtask

  task automatic randomTraffic(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 11) != 0);
      load = ($urandom_range(0, 7) == 0);
      k    = $urandom_range(0, 4);
      bcd  = 16'($urandom & ((1 << (4 * k)) - 1));
      dp   = 4'($urandom);
    end
    @(negedge clk);
    load = 1'b0; en = 1'b1;
  endtask

  initial begin : stimBlk
    int n;
    rstN = 1'b1; load = 1'b0; bcd = '0; dp = '0; en = 1'b1;
    #1 rstN = 1'b0;
    #1;
    check("rstA", {segA, dpA, digA, frA}, inactive(1'b0, 1'b0));
    check("rstB", {segB, dpB, digB, frB}, inactive(1'b1, 1'b1));
    idle(3);
    rstN = 1'b1;

    idle(10);
    loadVal(16'h1234, 4'b0000);  idle(40);
    loadVal(16'h0075, 4'b0100);  idle(40);
    loadVal(16'h0000, 4'b1000);  idle(40);
    loadVal(16'h00A0, 4'b0001);  idle(40);

    waitPhase(2);
    load = 1'b1; bcd = 16'h1111; dp = 4'b0000;
    @(negedge clk); load = 1'b0;
    idle(5);
    load = 1'b1; bcd = 16'h2222; dp = 4'b0010;
    @(negedge clk); load = 1'b0;
    idle(40);

    waitPhase(FRM - 1);
    load = 1'b1; bcd = 16'h9876; dp = 4'b1111;
    @(negedge clk); load = 1'b0;
    idle(40);

    @(negedge clk); en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(10);

    randomTraffic(300);

    // Asynchronous reset mid-scan, away from any clock edge
    loadVal(16'h0508, 4'b0011);
    idle(23);
    @(posedge clk);
    #2 rstN = 1'b0;
    sbQ.delete();
    #1;
    check("asyncRstA", {segA, dpA, digA, frA}, inactive(1'b0, 1'b0));
    check("asyncRstB", {segB, dpB, digB, frB}, inactive(1'b1, 1'b1));
    check("asyncRstC", {segC, dpC, digC, frC}, inactive(1'b1, 1'b0));
    idle(2);
    rstN = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (frA === 1'b1) break;
    end
    check("frameLatency", 13'(n), 13'd16);

    randomTraffic(150);
    idle(3);
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
